// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character-LCD blocks: engine states,
// controller command codes and default bus/execution timing at 50 MHz.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5
  } lcd_state_e;

  localparam logic [7:0] CMD_CLEAR         = 8'h01;
  localparam logic [7:0] CMD_HOME          = 8'h02;
  localparam logic [7:0] CMD_ENTRY_MODE    = 8'h06;
  localparam logic [7:0] CMD_DISPLAY_ON    = 8'h0E;
  localparam logic [7:0] CMD_FUNC_SET_8BIT = 8'h38;

  localparam int SETUP_CYC_DEF      = 2;
  localparam int PULSE_CYC_DEF      = 25;
  localparam int HOLD_CYC_DEF       = 2;
  localparam int WAIT_SHORT_CYC_DEF = 2000;
  localparam int WAIT_LONG_CYC_DEF  = 82000;
  localparam int CNT_W_DEF          = 17;

  // Clear and return-home (0x00..0x03 as commands) take the long execution time.
  function automatic logic needs_long_wait(input logic rs, input logic [7:0] cmd);
    return (rs == 1'b0) && (cmd[7:2] == 6'd0);
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter used for every timed phase of the LCD write engine.
// Load wins over counting; the count parks at zero instead of wrapping.
module lcd_delay_counter #(
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // Count state: load, decrement toward zero, or hold while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (enable) begin
      if (load) begin
        count_r <= load_value;
      end else if (count_r != '0) begin
        count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/lcd_write_engine.sv
// Multi-cycle custom instruction that writes one command/data byte to an
// HD44780 bus with cycle-counted setup, enable pulse, hold and execution wait.
module lcd_write_engine
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC      = SETUP_CYC_DEF,
  parameter int PULSE_CYC      = PULSE_CYC_DEF,
  parameter int HOLD_CYC       = HOLD_CYC_DEF,
  parameter int WAIT_SHORT_CYC = WAIT_SHORT_CYC_DEF,
  parameter int WAIT_LONG_CYC  = WAIT_LONG_CYC_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done,
  output logic        lcd_enable,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_data
);

  if (64'(WAIT_LONG_CYC) >= (64'd1 << CNT_W)) begin : g_cnt_w_check
    $error("lcd_write_engine: WAIT_LONG_CYC does not fit in CNT_W bits");
  end
  if ((SETUP_CYC < 1) || (PULSE_CYC < 1) || (HOLD_CYC < 1) ||
      (WAIT_SHORT_CYC < 1) || (WAIT_LONG_CYC < 1)) begin : g_cyc_check
    $error("lcd_write_engine: all *_CYC parameters must be at least 1");
  end

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SHORT_LD = CNT_W'(WAIT_SHORT_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(WAIT_LONG_CYC - 1);

  lcd_state_e       state_r;
  logic [7:0]       byte_r;
  logic             rs_r;
  logic             enable_r;
  logic             done_r;
  logic [31:0]      result_r;
  logic             load_s;
  logic [CNT_W-1:0] load_value_s;
  logic             zero_s;
  logic             unused_s;

  assign unused_s = ^{dataa[31:8], datab[31:1]};

  lcd_delay_counter #(.CNT_W(CNT_W)) u_delay (
    .clk        (clk),
    .reset      (reset),
    .enable     (clk_en),
    .load       (load_s),
    .load_value (load_value_s),
    .zero       (zero_s)
  );

  // Counter reload at each phase boundary.
  always_comb begin
    load_s       = 1'b0;
    load_value_s = '0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          load_s       = 1'b1;
          load_value_s = SETUP_LD;
        end else begin
          load_s = 1'b0;
        end
      end
      ST_SETUP: begin
        if (zero_s) begin
          load_s       = 1'b1;
          load_value_s = PULSE_LD;
        end else begin
          load_s = 1'b0;
        end
      end
      ST_PULSE: begin
        if (zero_s) begin
          load_s       = 1'b1;
          load_value_s = HOLD_LD;
        end else begin
          load_s = 1'b0;
        end
      end
      ST_HOLD: begin
        if (zero_s) begin
          load_s       = 1'b1;
          load_value_s = needs_long_wait(rs_r, byte_r) ? LONG_LD : SHORT_LD;
        end else begin
          load_s = 1'b0;
        end
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  // Write sequencer with registered bus, strobe, done and result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      byte_r   <= 8'h00;
      rs_r     <= 1'b0;
      enable_r <= 1'b0;
      done_r   <= 1'b0;
      result_r <= 32'd0;
    end else if (clk_en) begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            byte_r  <= dataa[7:0];
            rs_r    <= datab[0];
            state_r <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (zero_s) begin
            enable_r <= 1'b1;
            state_r  <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (zero_s) begin
            enable_r <= 1'b0;
            state_r  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (zero_s) begin
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (zero_s) begin
            result_r <= {23'd0, rs_r, byte_r};
            done_r   <= 1'b1;
            state_r  <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          enable_r <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign result     = result_r;
  assign done       = done_r;
  assign lcd_enable = enable_r;
  assign lcd_rs     = rs_r;
  assign lcd_rw     = 1'b0;
  assign lcd_data   = byte_r;

endmodule

// File: tb/tb_lcd_write_engine.sv
// Self-checking bench for lcd_write_engine: vector table plus hand-written
// sequences, with a done-time scoreboard and an enable-pulse monitor.
module tb_lcd_write_engine;

  localparam int SETUP = 2;
  localparam int PULSE = 25;
  localparam int HOLD  = 2;
  localparam int WS    = 40;
  localparam int WL    = 300;
  localparam int LAT_S = 1 + SETUP + PULSE + HOLD + WS;
  localparam int LAT_L = 1 + SETUP + PULSE + HOLD + WL;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dataa = 32'd0;
  logic [31:0] datab = 32'd0;
  logic [31:0] result;
  logic        done;
  logic        lcd_enable;
  logic        lcd_rs;
  logic        lcd_rw;
  logic [7:0]  lcd_data;

  lcd_write_engine #(
    .SETUP_CYC(SETUP), .PULSE_CYC(PULSE), .HOLD_CYC(HOLD),
    .WAIT_SHORT_CYC(WS), .WAIT_LONG_CYC(WL), .CNT_W(17)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
    .dataa(dataa), .datab(datab), .result(result), .done(done),
    .lcd_enable(lcd_enable), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          long_w;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   pulses = 0;
  int   raw_w = 0;
  int   en_w = 0;
  int   last_raw = 0;
  int   rise_cyc = 0;
  logic prev_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard and enable-pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("result", result, e.res);
        check("lcd_rw", {31'd0, lcd_rw}, 32'd0);
      end
    end
    if (lcd_enable) begin
      if (!prev_en) rise_cyc = cyc;
      raw_w++;
      if (clk_en) en_w++;
    end else if (prev_en) begin
      check("pulse_width", en_w, PULSE);
      last_raw = raw_w;
      pulses++;
      raw_w = 0;
      en_w = 0;
    end
    prev_en = lcd_enable;
  end

  // Called at posedge+1; start is sampled at the next edge (cycle t).
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                       input bit long_w, input int extra, output int t);
    exp_t e;
    t = cyc;
    e.res = res;
    e.cyc = t + (long_w ? LAT_L : LAT_S) + extra;
    sb.push_back(e);
    dataa = a;
    datab = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dataa = 32'h0000_00C3;
    datab = 32'd0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < LAT_L + 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int t;
    int p0;
    vecs[0] = '{32'h0000_0041, 32'h1,         32'h141, 1'b0};
    vecs[1] = '{32'h0000_0001, 32'h0,         32'h001, 1'b1};
    vecs[2] = '{32'h0000_0038, 32'h0,         32'h038, 1'b0};
    vecs[3] = '{32'h0000_0002, 32'h0,         32'h002, 1'b1};
    vecs[4] = '{32'h0000_0000, 32'h0,         32'h000, 1'b1};
    vecs[5] = '{32'h0000_0003, 32'h1,         32'h103, 1'b0};
    vecs[6] = '{32'hFFFF_FF04, 32'hFFFF_FFFE, 32'h004, 1'b0};
    vecs[7] = '{32'h1234_5603, 32'h0000_0002, 32'h003, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_enable", {31'd0, lcd_enable}, 32'd0);
    check("rst_rs", {31'd0, lcd_rs}, 32'd0);
    check("rst_rw", {31'd0, lcd_rw}, 32'd0);
    check("rst_data", {24'd0, lcd_data}, 32'd0);
    check("rst_result", result, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Data write 0x41: bus valid from t+1, strobe rises at t+3.
    issue(32'h41, 32'h1, 32'h141, 1'b0, 0, t);
    check("t1_data", {24'd0, lcd_data}, 32'h41);
    check("t1_rs", {31'd0, lcd_rs}, 32'd1);
    check("t1_enable_low", {31'd0, lcd_enable}, 32'd0);
    wait_idle();
    check("t1_rise_cycle", rise_cyc, t + 3);
    @(posedge clk); #1;
    check("idle_keeps_data", {24'd0, lcd_data}, 32'h41);

    // Table of single writes, each started in the first IDLE cycle.
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].long_w, 0, t);
      check("vec_data", {24'd0, lcd_data}, {24'd0, vecs[i].res[7:0]});
      check("vec_rs", {31'd0, lcd_rs}, {31'd0, vecs[i].res[8]});
      wait_idle();
      @(posedge clk); #1;
    end

    // Back-to-back 0x38 then HOME: two separate strobes.
    p0 = pulses;
    issue(32'h38, 32'h0, 32'h038, 1'b0, 0, t);
    wait_idle();
    @(posedge clk); #1;
    issue(32'h02, 32'h0, 32'h002, 1'b1, 0, t);
    wait_idle();
    check("b2b_pulses", pulses - p0, 2);
    @(posedge clk); #1;

    // start during PULSE, WAIT and DONE is ignored.
    issue(32'h55, 32'h1, 32'h155, 1'b0, 0, t);
    wait_cyc(t + 5);
    for (int k = 0; k < 4; k++) begin
      dataa = 32'hFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("ign_pulse_data", {24'd0, lcd_data}, 32'h55);
      @(posedge clk); #1;
    end
    wait_cyc(t + 40);
    for (int k = 0; k < 4; k++) begin
      dataa = 32'hFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("ign_wait_data", {24'd0, lcd_data}, 32'h55);
    end
    wait_cyc(t + LAT_S);
    dataa = 32'hAA; datab = 32'h0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ign_done_data", {24'd0, lcd_data}, 32'h55);
    check("ign_done_rs", {31'd0, lcd_rs}, 32'd1);
    repeat (LAT_L + 10) @(posedge clk);
    #1;

    // clk_en low for 10 cycles inside the strobe stretches everything by 10.
    issue(32'h41, 32'h1, 32'h141, 1'b0, 10, t);
    wait_cyc(t + 10);
    clk_en = 1'b0;
    wait_cyc(t + 20);
    clk_en = 1'b1;
    wait_idle();
    check("clken_raw_width", last_raw, PULSE + 10);
    @(posedge clk); #1;

    // Asynchronous reset in WAIT aborts with no done.
    issue(32'h21, 32'h1, 32'h121, 1'b0, 0, t);
    wait_cyc(t + 40);
    #2;
    reset = 1'b1;
    #1;
    sb.delete();
    check("ar_enable", {31'd0, lcd_enable}, 32'd0);
    check("ar_rs", {31'd0, lcd_rs}, 32'd0);
    check("ar_data", {24'd0, lcd_data}, 32'd0);
    check("ar_result", result, 32'd0);
    check("ar_done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_cyc(t + LAT_S + 10);
    check("ar_result_after", result, 32'd0);
    issue(32'h42, 32'h1, 32'h142, 1'b0, 0, t);
    wait_idle();

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_write_engine.md
Name: lcd_write_engine

Overview:
- Nios II multi-cycle custom-instruction block that sits directly downstream of the LCD initialization sequencer on the same HD44780 character-LCD bus.
- Takes one command or character byte per instruction and drives the 8-bit parallel bus with correct setup, enable-pulse and hold timing.
- Waits out the controller execution time, then asserts done.
- Replaces delay-based sequencing with cycle-counted, synthesizable timing.

Parameters:
- SETUP_CYC, 2, clocks rs/rw/data are stable before lcd_enable rises (tAS).
- PULSE_CYC, 25, clocks lcd_enable is held high (500 ns at 50 MHz).
- HOLD_CYC, 2, clocks data is held after lcd_enable falls (tH).
- WAIT_SHORT_CYC, 2000, execution wait for normal commands and data (40 us).
- WAIT_LONG_CYC, 82000, execution wait for clear/home commands (1.64 ms).
- CNT_W, 17, delay counter width; must hold WAIT_LONG_CYC.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clk_en  in  1  custom-instruction clock enable; when 0 all state holds
- start  in  1  one-cycle instruction start
- dataa  in  32  [7:0] = byte to write
- datab  in  32  [0] = rs (0 command, 1 data); [31:1] ignored
- result  out  32  {23'b0, rs, byte} of the last completed write
- done  out  1  one-cycle completion pulse
- lcd_enable  out  1  LCD E strobe
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write; tied low (write only)
- lcd_data  out  8  LCD data bus

Behaviour:
- Clocking and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, counter=0, done=0, lcd_enable=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00, result=0.
- Reset mid-operation: an assertion in any state aborts immediately and forces the reset values. No done pulse is issued for the aborted write.
- Clock enable: all registers update only when clk_en=1. When clk_en=0, outputs and counter hold their values.
- States: IDLE, SETUP, PULSE, HOLD, WAIT, DONE.
- IDLE: when start=1 and clk_en=1:
  - latch byte=dataa[7:0] and rs=datab[0];
  - drive lcd_data and lcd_rs;
  - load counter=SETUP_CYC-1;
  - go to SETUP.
- SETUP: lcd_enable=0. When counter=0, load PULSE_CYC-1 and go to PULSE; otherwise decrement.
- PULSE: lcd_enable=1. When counter=0, load HOLD_CYC-1 and go to HOLD; otherwise decrement.
- HOLD: lcd_enable=0, bus unchanged. When counter=0, load the wait value and go to WAIT.
  - Wait value is WAIT_LONG_CYC-1 when rs=0 and byte[7:2]=0 (clear 0x01, home 0x02/0x03).
  - Otherwise it is WAIT_SHORT_CYC-1.
- WAIT: decrement. When counter=0:
  - result <= {23'b0, rs, byte};
  - go to DONE.
- DONE: done=1 for exactly one enabled cycle, then IDLE. lcd_data and lcd_rs keep their last values in IDLE.
- Byte 0x00 with rs=0 is a legal command and gets the long wait.
- Latency: with start sampled at cycle T, done is high in cycle T+1+SETUP_CYC+PULSE_CYC+HOLD_CYC+WAIT_x.
  - Defaults, short wait: T+2030.
  - Defaults, long wait: T+82030.
- start outside IDLE is ignored: no re-latch, no effect on timing.
- start asserted in the DONE cycle is ignored. start in the first IDLE cycle after DONE is accepted.
- Each lcd_enable pulse is exactly PULSE_CYC enabled cycles wide, with no glitches. All LCD outputs are registered.
- Parameter constraints: all *_CYC parameters must be ≥1. An elaboration-time check fails the build if WAIT_LONG_CYC ≥ 2^CNT_W.

Decomposition:
- Shared package lcd_pkg:
  - state enumeration;
  - HD44780 command constants (CLEAR=8'h01, HOME=8'h02, ENTRY_MODE=8'h06, DISPLAY_ON=8'h0E, FUNC_SET_8BIT=8'h38);
  - the default timing constants.
- The initialization sequencer uses the same package.
- Sub-module lcd_delay_counter: loadable down-counter of CNT_W bits with load, load_value, enable (clk_en) and zero outputs. Asynchronous active-high reset to 0.

Test Plan:
- Write data 0x41 (dataa=32'h41, datab=1) -> lcd_rs=1 and lcd_data=0x41 from T+1; lcd_enable high exactly 25 cycles starting at T+3; done at T+2030; result=32'h141.
- Write command 0x01 (datab=0) -> lcd_rs=0, same enable timing; done at T+82030; result=32'h001.
- Command 0x38, then command 0x02 back-to-back (next start the cycle after IDLE is re-entered) -> first done at T+2030, second uses the long wait; two distinct enable pulses; lcd_rw=0 throughout.
- start pulsed repeatedly during PULSE and WAIT with dataa=0xFF -> ignored; lcd_data stays at the original byte; a single done at the nominal cycle.
- clk_en held low for 10 cycles during PULSE -> lcd_enable stays high for 25 enabled cycles (35 clocks); done is delayed by exactly 10 cycles.
- reset asserted asynchronously mid-WAIT -> all outputs return to reset values within the same cycle; no done; a new start afterwards completes normally.
